// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles the instruction-memory request/response signals and the decode
// valid/ready handshake of the fetch front end.
//   pc          fetch address to instruction memory
//   mem_inst    memory read data for the pc sampled at the previous edge
//   inst_out    instruction presented to decode (buffer head)
//   inst_pc     pc of inst_out
//   inst_valid  buffer head valid
//   inst_ready  decode accepts the head this cycle
//   redirect    flush in-flight/buffered work and restart fetch
//   redirect_pc restart address when redirect=1
// master: the fetch unit.  slave: memory + decode + branch logic.
// ---------------------------------------------------------------------------
interface fetch_unit_if;
   logic [31:0] pc;
   logic [31:0] mem_inst;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output pc, inst_out, inst_pc, inst_valid,
      input  mem_inst, inst_ready, redirect, redirect_pc
   );

   modport slave (
      input  pc, inst_out, inst_pc, inst_valid,
      output mem_inst, inst_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Issues word-indexed PCs to a memory that
// returns data one cycle after sampling the PC, captures each returned word
// with its PC in a 2-entry FIFO, and hands the head to decode over a
// valid/ready handshake. A redirect squashes the in-flight request and the
// buffered words and restarts fetch at redirect_pc.
// Ports:
//   clk          system clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   bus          fetch_unit_if.master (pc, mem_inst, inst_out, inst_pc,
//                inst_valid, inst_ready, redirect, redirect_pc)
//   perf_fetched instructions accepted by decode (FETCH_PERF_EN only)
//   perf_stall   cycles with a valid head refused by decode (FETCH_PERF_EN)
// Optional feature macro: FETCH_PERF_EN adds the saturating counters above.
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter logic [31:0] PC_STEP  = 32'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);

   logic [1:0]  count_reg;
   logic        rd_ptr_reg;
   logic        wr_ptr_reg;
   logic        inflight_reg;
   logic [31:0] inflight_pc_reg;
   logic [31:0] pc_reg;
   logic [31:0] buf_inst_reg [2];
   logic [31:0] buf_pc_reg   [2];

   logic        head_valid;
   logic        pop;
   logic        accept;
   logic        push;
   logic        issue;
   logic [2:0]  occupancy;

   assign head_valid = (count_reg != 2'd0);
   assign pop        = head_valid & bus.inst_ready;
   // A redirect cycle never consumes the head or captures the response.
   assign accept     = pop & ~bus.redirect;
   assign push       = inflight_reg & ~bus.redirect;
   // Slots that will be committed after this edge, counting the word still
   // in flight; a new request is only issued if it is guaranteed a slot.
   assign occupancy  = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
   assign issue      = ~bus.redirect & (occupancy < 3'd2);

   // Buffer storage: one register pair per entry, written at the tail.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               buf_inst_reg[gi] <= 32'd0;
               buf_pc_reg[gi]   <= 32'd0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
               buf_inst_reg[gi] <= bus.mem_inst;
               buf_pc_reg[gi]   <= inflight_pc_reg;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg          <= RESET_PC;
         count_reg       <= 2'd0;
         rd_ptr_reg      <= 1'b0;
         wr_ptr_reg      <= 1'b0;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= 32'd0;
      end else if (bus.redirect) begin
         pc_reg       <= bus.redirect_pc;
         count_reg    <= 2'd0;
         rd_ptr_reg   <= 1'b0;
         wr_ptr_reg   <= 1'b0;
         inflight_reg <= 1'b0;
      end else begin
         count_reg <= count_reg + 2'(push) - 2'(accept);
         if (push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (accept) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         if (issue) begin
            inflight_reg    <= 1'b1;
            inflight_pc_reg <= pc_reg;
            pc_reg          <= pc_reg + PC_STEP;
         end else begin
            inflight_reg <= 1'b0;
         end
      end
   end

   assign bus.pc         = pc_reg;
   assign bus.inst_out   = buf_inst_reg[rd_ptr_reg];
   assign bus.inst_pc    = buf_pc_reg[rd_ptr_reg];
   assign bus.inst_valid = head_valid;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= 32'd0;
         perf_stall   <= 32'd0;
      end else begin
         if (accept && (perf_fetched != 32'hFFFF_FFFF)) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (head_valid && !bus.inst_ready && (perf_stall != 32'hFFFF_FFFF)) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. The reference model keeps the fetch
// buffer as a queue of PCs plus a single in-flight slot; instruction data is
// implied by the memory image memdata[k] = k + 32'h100.
// Compile with FETCH_PERF_EN defined to also check the perf counters.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] STEP = 32'd1;
   localparam logic [31:0] MEM_OFS = 32'h100;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetch_unit_if bus ();
   fetch_unit_if bus2 ();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

   fetch_unit #(.RESET_PC(32'd0), .PC_STEP(STEP)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .PC_STEP(STEP)) dut2 (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus2)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched2),
      .perf_stall   (perf_stall2)
`endif
   );

   // Instruction memories: register memdata[pc] on every edge.
   always @(posedge clk) begin
      bus.mem_inst  <= bus.pc + MEM_OFS;
      bus2.mem_inst <= bus2.pc + MEM_OFS;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [31:0] m_q [$];
   bit          m_infl;
   logic [31:0] m_infl_pc;
   logic [31:0] m_pc;
   logic [31:0] m_fetched;
   logic [31:0] m_stall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset(input logic [31:0] rpc);
      m_q.delete();
      m_infl    = 1'b0;
      m_infl_pc = 32'd0;
      m_pc      = rpc;
      m_fetched = 32'd0;
      m_stall   = 32'd0;
   endtask

   // Called at a negedge: compare outputs, drive inputs for the next edge,
   // advance the model by one edge, then move to the following negedge.
   task automatic run_cycle(input bit rdy, input bit rd, input logic [31:0] rpc);
      bit          mv;
      bit          iss;
      int          occ;
      logic [31:0] head;
      mv   = (m_q.size() != 0);
      head = mv ? m_q[0] : 32'd0;
      check("pc", bus.pc, m_pc);
      check("inst_valid", {31'd0, bus.inst_valid}, {31'd0, mv});
      if (mv) begin
         check("inst_pc", bus.inst_pc, head);
         check("inst_out", bus.inst_out, head + MEM_OFS);
      end
      check("count", {30'd0, dut.count_reg}, 32'(m_q.size()));
      check("count_le_2", {31'd0, (dut.count_reg <= 2'd2)}, 32'd1);
`ifdef FETCH_PERF_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_stall", perf_stall, m_stall);
`endif
      bus.inst_ready  = rdy;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;

      if (mv && !rdy) m_stall++;
      occ = m_q.size() + int'(m_infl) - int'(mv && rdy);
      iss = !rd && (occ < 2);
      if (rd) begin
         m_q.delete();
         m_infl = 1'b0;
         m_pc   = rpc;
         $display("[TB] redirect to %h", rpc);
      end else begin
         if (mv && rdy) begin
            $display("[TB] accept pc=%h inst=%h", head, head + MEM_OFS);
            void'(m_q.pop_front());
            m_fetched++;
         end
         if (m_infl) m_q.push_back(m_infl_pc);
         if (iss) begin
            m_infl    = 1'b1;
            m_infl_pc = m_pc;
            m_pc      = m_pc + STEP;
         end else begin
            m_infl = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.inst_ready   = 1'b1;
      bus.redirect     = 1'b0;
      bus.redirect_pc  = 32'd0;
      bus2.inst_ready  = 1'b1;
      bus2.redirect    = 1'b0;
      bus2.redirect_pc = 32'd0;
      model_reset(32'd0);
      repeat (2) @(negedge clk);

      check("rst_inst_out", bus.inst_out, 32'd0);
      check("rst_inst_pc", bus.inst_pc, 32'd0);
      check("rst_pc2", bus2.pc, 32'hFFFF_FFFF);
      rst_n = 1'b1;

      // Start-up stream; the second instance checks PC wrap from FFFFFFFF.
      for (int k = 0; k < 10; k++) begin
         if (k >= 2 && k <= 4) begin
            check("wrap_valid", {31'd0, bus2.inst_valid}, 32'd1);
            check("wrap_pc", bus2.inst_pc, 32'hFFFF_FFFF + 32'(k - 2));
            check("wrap_inst", bus2.inst_out, 32'hFFFF_FFFF + 32'(k - 2) + MEM_OFS);
         end
         run_cycle(1'b1, 1'b0, 32'd0);
      end

      // Decode stall, then release.
      for (int k = 0; k < 10; k++) run_cycle(1'b0, 1'b0, 32'd0);
      for (int k = 0; k < 6; k++)  run_cycle(1'b1, 1'b0, 32'd0);

      // Redirect with a full buffer, and with one word in flight.
      for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b0, 32'd0);
      run_cycle(1'b1, 1'b1, 32'd40);
      for (int k = 0; k < 6; k++) run_cycle(1'b1, 1'b0, 32'd0);
      run_cycle(1'b0, 1'b0, 32'd0);
      run_cycle(1'b1, 1'b1, 32'd40);
      for (int k = 0; k < 5; k++) run_cycle(1'b1, 1'b0, 32'd0);

      // Back-to-back redirects: latest wins.
      run_cycle(1'b1, 1'b1, 32'd10);
      run_cycle(1'b1, 1'b1, 32'd20);
      for (int k = 0; k < 6; k++) run_cycle(1'b1, 1'b0, 32'd0);

      // Five deliveries, then stall with a valid head, then async reset.
      for (int k = 0; k < 5; k++) run_cycle(1'b1, 1'b0, 32'd0);
      for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b0, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_pc", bus.pc, 32'd0);
      check("async_valid", {31'd0, bus.inst_valid}, 32'd0);
      check("async_inst_pc", bus.inst_pc, 32'd0);
      check("async_inst_out", bus.inst_out, 32'd0);
`ifdef FETCH_PERF_EN
      check("async_perf_fetched", perf_fetched, 32'd0);
      check("async_perf_stall", perf_stall, 32'd0);
`endif
      model_reset(32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         bit          rdy;
         bit          rd;
         logic [31:0] rpc;
         rdy = ($urandom_range(0, 9) < 7);
         rd  = ($urandom_range(0, 19) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
         run_cycle(rdy, rd, rpc);
      end
      for (int k = 0; k < 4; k++) run_cycle(1'b1, 1'b0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
